cpu_controller: RTL and testbench

- Instruction register, decoder and Moore FSM that sits directly upstream of the datapath and drives every datapath control input.
- Executes one 16-bit instruction per start pulse: MOV imm, MOV reg, ADD, CMP, AND, MVN.
- Signals completion to the outside via w (waiting).

---
 rtl/cpu_controller.sv | 142 ++++++++++++++
 tb/tb_cpu_controller.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - instruction register, decoder and Moore control FSM driving the datapath
// One instruction per start pulse; w is high only while idle in WAIT.
module cpu_controller #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [15:0]   in,
  input  logic          load,
  input  logic          s,
  output logic          w,
  output logic [2:0]    readnum,
  output logic [2:0]    writenum,
  output logic          write,
  output logic [1:0]    vsel,
  output logic          loada,
  output logic          loadb,
  output logic          loadc,
  output logic          loads,
  output logic          asel,
  output logic          bsel,
  output logic [1:0]    shift,
  output logic [1:0]    ALUop,
  output logic [DW-1:0] sximm8,
  output logic [DW-1:0] sximm5
);

  typedef enum logic [2:0] {
    S_WAIT,
    S_DECODE,
    S_WRITE_IMM,
    S_GET_A,
    S_GET_B,
    S_CALC,
    S_WRITE_REG
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] ir_q, ir_d;

  logic [2:0] opcode, rn, rd, rm;
  logic [1:0] op, sh;
  logic       is_mov_imm, is_mov_reg, is_alu, is_mvn, is_cmp;

  assign opcode = ir_q[15:13];
  assign op     = ir_q[12:11];
  assign rn     = ir_q[10:8];
  assign rd     = ir_q[7:5];
  assign sh     = ir_q[4:3];
  assign rm     = ir_q[2:0];

  assign is_mov_imm = (opcode == 3'b110) && (op == 2'b10);
  assign is_mov_reg = (opcode == 3'b110) && (op == 2'b00);
  assign is_alu     = (opcode == 3'b101);
  assign is_mvn     = is_alu && (op == 2'b11);
  assign is_cmp     = is_alu && (op == 2'b01);

  assign sximm8 = {{(DW-8){ir_q[7]}}, ir_q[7:0]};
  assign sximm5 = {{(DW-5){ir_q[4]}}, ir_q[4:0]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_WAIT;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // IR only accepts a new word while idle, so a running instruction cannot be corrupted.
  always_comb begin
    ir_d = ir_q;
    if (load && (state_q == S_WAIT)) ir_d = in;
  end

  always_comb begin
    state_d  = state_q;
    w        = 1'b0;
    readnum  = 3'b000;
    writenum = 3'b000;
    write    = 1'b0;
    vsel     = 2'b00;
    loada    = 1'b0;
    loadb    = 1'b0;
    loadc    = 1'b0;
    loads    = 1'b0;
    asel     = 1'b0;
    bsel     = 1'b0;
    shift    = 2'b00;
    ALUop    = 2'b00;
    case (state_q)
      S_WAIT: begin
        w = 1'b1;
        if (s) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (is_mov_imm)                    state_d = S_WRITE_IMM;
        else if (is_mov_reg || is_mvn)     state_d = S_GET_B;
        else if (is_alu)                   state_d = S_GET_A;
        else                               state_d = S_WAIT;
      end
      S_WRITE_IMM: begin
        writenum = rn;
        vsel     = 2'b10;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      S_GET_A: begin
        readnum = rn;
        loada   = 1'b1;
        state_d = S_GET_B;
      end
      S_GET_B: begin
        readnum = rm;
        loadb   = 1'b1;
        state_d = S_CALC;
      end
      S_CALC: begin
        shift = sh;
        ALUop = is_mov_reg ? 2'b00 : op;
        asel  = is_mov_reg;
        // CMP only updates status; everything else latches C for writeback.
        if (is_cmp) begin
          loads   = 1'b1;
          state_d = S_WAIT;
        end else begin
          loadc   = 1'b1;
          state_d = S_WRITE_REG;
        end
      end
      S_WRITE_REG: begin
        writenum = rd;
        vsel     = 2'b00;
        write    = 1'b1;
        state_d  = S_WAIT;
      end
      default: state_d = S_WAIT;
    endcase
  end

endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - scoreboard bench for cpu_controller with a behavioural datapath
module tb_cpu_controller;

  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [15:0]   in_i;
  logic          load, s;
  logic          w, write, loada, loadb, loadc, loads, asel, bsel;
  logic [2:0]    readnum, writenum;
  logic [1:0]    vsel, shift, aluop;
  logic [DW-1:0] sximm8, sximm5;

  cpu_controller #(.DW(DW)) dut (
    .clk(clk), .reset(reset), .in(in_i), .load(load), .s(s), .w(w),
    .readnum(readnum), .writenum(writenum), .write(write), .vsel(vsel),
    .loada(loada), .loadb(loadb), .loadc(loadc), .loads(loads),
    .asel(asel), .bsel(bsel), .shift(shift), .ALUop(aluop),
    .sximm8(sximm8), .sximm5(sximm5)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       w;
    logic [2:0] readnum;
    logic [2:0] writenum;
    logic       write;
    logic [1:0] vsel;
    logic       loada, loadb, loadc, loads, asel, bsel;
    logic [1:0] shift;
    logic [1:0] aluop;
  } ctl_t;

  ctl_t exp_q[$];
  int   vectors = 0;
  int   miscompares = 0;

  // Behavioural datapath so instruction results can be checked end to end
  logic [15:0] rf [8];
  logic [15:0] ra, rb, rc, bsh, ain, bin, alu_out;
  logic        z_flag;
  int          write_count = 0;

  always_comb begin
    case (shift)
      2'b01:   bsh = {rb[14:0], 1'b0};
      2'b10:   bsh = {1'b0, rb[15:1]};
      2'b11:   bsh = {rb[15], rb[15:1]};
      default: bsh = rb;
    endcase
    ain = asel ? 16'h0000 : ra;
    bin = bsel ? sximm5 : bsh;
    case (aluop)
      2'b00:   alu_out = ain + bin;
      2'b01:   alu_out = ain - bin;
      2'b10:   alu_out = ain & bin;
      default: alu_out = ~bin;
    endcase
  end

  always @(posedge clk) begin
    if (write) begin
      rf[writenum] <= (vsel == 2'b10) ? sximm8 : rc;
      write_count  <= write_count + 1;
    end
    if (loada) ra <= rf[readnum];
    if (loadb) rb <= rf[readnum];
    if (loadc) rc <= alu_out;
    if (loads) z_flag <= (alu_out == 16'h0000);
  end

  function automatic ctl_t obs();
    return ctl_t'({w, readnum, writenum, write, vsel, loada, loadb, loadc, loads,
                   asel, bsel, shift, aluop});
  endfunction

  // Reference sequence of control vectors, one per edge after s is sampled
  task automatic push_model(input logic [15:0] ir);
    ctl_t c;
    logic [2:0] opc, rn, rd, rm;
    logic [1:0] op, sh;
    logic mov_imm, mov_reg, alu, cmp;
    opc = ir[15:13]; op = ir[12:11]; rn = ir[10:8]; rd = ir[7:5]; sh = ir[4:3]; rm = ir[2:0];
    mov_imm = (opc == 3'b110) && (op == 2'b10);
    mov_reg = (opc == 3'b110) && (op == 2'b00);
    alu     = (opc == 3'b101);
    cmp     = alu && (op == 2'b01);
    c = '0; exp_q.push_back(c);
    if (mov_imm) begin
      c = '0; c.writenum = rn; c.vsel = 2'b10; c.write = 1'b1; exp_q.push_back(c);
    end else if (alu || mov_reg) begin
      if (alu && op != 2'b11) begin
        c = '0; c.readnum = rn; c.loada = 1'b1; exp_q.push_back(c);
      end
      c = '0; c.readnum = rm; c.loadb = 1'b1; exp_q.push_back(c);
      c = '0; c.shift = sh; c.aluop = mov_reg ? 2'b00 : op; c.asel = mov_reg;
      if (cmp) c.loads = 1'b1; else c.loadc = 1'b1;
      exp_q.push_back(c);
      if (!cmp) begin
        c = '0; c.writenum = rd; c.write = 1'b1; exp_q.push_back(c);
      end
    end
    c = '0; c.w = 1'b1; exp_q.push_back(c);
  endtask

  task automatic run_instr(input logic [15:0] instr, input int exp_lat, input int inject_k,
                           input string name);
    ctl_t e, o;
    int   k;
    exp_q.delete();
    push_model(instr);
    in_i = instr; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0; k = 0;
    while (1) begin
      o = obs();
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL %s ctl edge%0d: got %h, required none (sequence too long)", name, k, o);
      end else begin
        e = exp_q.pop_front();
        if (o !== e) begin
          miscompares++;
          $display("FAIL %s ctl edge%0d: got %h, required %h", name, k, o, e);
        end
      end
      if (w === 1'b1 || k >= 16) break;
      if (k == inject_k) begin
        s = 1'b1; load = 1'b1; in_i = 16'hD20D;
      end else begin
        s = 1'b0; load = 1'b0;
      end
      @(posedge clk); #1;
      k++;
    end
    s = 1'b0; load = 1'b0;
    vectors++;
    if (k != exp_lat) begin
      miscompares++;
      $display("FAIL %s latency: got %0d, required %0d", name, k, exp_lat);
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL %s drain: %0d vectors left, required 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; in_i = 16'h0000; load = 1'b0; s = 1'b0;
    #13;
    vectors++;
    if (obs() !== ctl_t'(20'h80000)) begin
      miscompares++;
      $display("FAIL reset ctl: got %h, required %h", obs(), 20'h80000);
    end
    vectors++;
    if (sximm8 !== 16'h0000 || sximm5 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset imm: got %h/%h, required 0000/0000", sximm8, sximm5);
    end
    @(posedge clk); #1; reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_mov_imm();
    run_instr(16'hD32A, 2, -1, "mov_r3_42");
    run_instr(16'hD20D, 2, -1, "mov_r2_13");
    vectors++;
    if (sximm8 !== 16'h000D) begin
      miscompares++;
      $display("FAIL mov_imm sximm8: got %h, required 000D", sximm8);
    end
    vectors++;
    if (rf[2] !== 16'd13 || rf[3] !== 16'd42) begin
      miscompares++;
      $display("FAIL mov_imm regs: got R2=%h R3=%h, required 000d 002a", rf[2], rf[3]);
    end
  endtask

  task automatic test_neg_imm();
    run_instr(16'hD1FD, 2, -1, "mov_r1_m3");
    vectors++;
    if (sximm8 !== 16'hFFFD || sximm5 !== 16'hFFFD) begin
      miscompares++;
      $display("FAIL neg_imm sext: got %h/%h, required FFFD/FFFD", sximm8, sximm5);
    end
    run_instr(16'hD0FA, 2, -1, "mov_r0_m6");
    vectors++;
    if (rf[1] !== 16'hFFFD || rf[0] !== 16'hFFFA) begin
      miscompares++;
      $display("FAIL neg_imm regs: got R1=%h R0=%h, required fffd fffa", rf[1], rf[0]);
    end
  endtask

  task automatic test_add();
    run_instr(16'hA3A2, 5, -1, "add_r5");
    vectors++;
    if (rf[5] !== 16'd55) begin
      miscompares++;
      $display("FAIL add result: got %0d, required 55", rf[5]);
    end
  endtask

  task automatic test_cmp();
    int wc;
    wc = write_count;
    run_instr(16'hA809, 4, -1, "cmp_r0_r1");
    vectors++;
    if (write_count != wc || z_flag !== 1'b1) begin
      miscompares++;
      $display("FAIL cmp effects: got writes=%0d z=%b, required writes=%0d z=1",
               write_count - wc, z_flag, 0);
    end
  endtask

  task automatic test_mov_reg_mvn();
    run_instr(16'hC08D, 4, -1, "mov_r4_r5_lsl");
    vectors++;
    if (rf[4] !== 16'd110) begin
      miscompares++;
      $display("FAIL mov_reg result: got %0d, required 110", rf[4]);
    end
    run_instr(16'hB8E2, 4, -1, "mvn_r7_r2");
    vectors++;
    if (rf[7] !== 16'hFFF2) begin
      miscompares++;
      $display("FAIL mvn result: got %h, required fff2", rf[7]);
    end
  endtask

  task automatic test_illegal();
    int wc;
    wc = write_count;
    run_instr(16'hDA00, 1, -1, "illegal_110_11");
    run_instr(16'h0000, 1, -1, "illegal_000");
    vectors++;
    if (write_count != wc) begin
      miscompares++;
      $display("FAIL illegal writes: got %0d, required 0", write_count - wc);
    end
  endtask

  task automatic test_back_to_back();
    int wc;
    run_instr(16'hA3A2, 5, 2, "add_with_s_in_get_b");
    wc = write_count;
    vectors++;
    if (sximm8 !== 16'hFFA2) begin
      miscompares++;
      $display("FAIL ignore_load IR: got sximm8=%h, required ffa2", sximm8);
    end
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (w !== 1'b1 || write_count != wc) begin
      miscompares++;
      $display("FAIL ignore_s idle: got w=%b writes=%0d, required w=1 writes=0", w, write_count - wc);
    end
  endtask

  task automatic test_reset_mid();
    int wc;
    wc = write_count;
    in_i = 16'hA3C2; load = 1'b1; s = 1'b1;
    @(posedge clk); #1;
    load = 1'b0; s = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (loadc !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid calc: got loadc=%b, required 1", loadc);
    end
    #2 reset = 1'b1;
    #1;
    vectors++;
    if (obs() !== ctl_t'(20'h80000)) begin
      miscompares++;
      $display("FAIL reset_mid ctl: got %h, required %h", obs(), 20'h80000);
    end
    vectors++;
    if (sximm8 !== 16'h0000 || sximm5 !== 16'h0000) begin
      miscompares++;
      $display("FAIL reset_mid IR: got %h/%h, required 0000/0000", sximm8, sximm5);
    end
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if (write_count != wc || w !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_mid writes: got %0d w=%b, required 0 w=1", write_count - wc, w);
    end
  endtask

  initial begin
    test_reset();
    test_mov_imm();
    test_neg_imm();
    test_add();
    test_cmp();
    test_mov_reg_mvn();
    test_illegal();
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
